// File: rtl/fir_pkg.sv
// fir_pkg: widths shared with the FIR core and the output round/saturate helper.
package fir_pkg;
   localparam int Y_WIDTH        = 36;
   localparam int OUT_DATA_WIDTH = 21;
   localparam int DROP_CNT_W     = 16;

   typedef struct packed {
      logic                      sat;
      logic [OUT_DATA_WIDTH-1:0] val;
   } round_sat_t;

   // Round half up, shift, clamp; the extra top bit keeps the rounding add from wrapping.
   function automatic round_sat_t fir_round_sat(input logic [Y_WIDTH-1:0] y, input int unsigned shift);
      logic [Y_WIDTH:0] t;
      logic [Y_WIDTH:0] s;
      round_sat_t       r;
      t = {1'b0, y} + ((shift > 0) ? ((Y_WIDTH+1)'(1) << (shift - 1)) : '0);
      s = t >> shift;
      r.sat = |s[Y_WIDTH:OUT_DATA_WIDTH];
      r.val = r.sat ? '1 : s[OUT_DATA_WIDTH-1:0];
      return r;
   endfunction
endpackage

// File: rtl/fir_out_fifo.sv
// fir_out_fifo: show-ahead FIFO; a push into a full FIFO is accepted only alongside a pop.
module fir_out_fifo #(
   parameter int W     = 21,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [W-1:0]           data_i,
   output logic [W-1:0]           data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   lvl_q, lvl_d;
   logic          push_ok, pop_ok;

   assign empty_o = lvl_q == '0;
   assign full_o  = lvl_q == (AW+1)'(DEPTH);
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);
   assign wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
   assign rd_d    = pop_ok ? rd_q + AW'(1) : rd_q;
   assign lvl_d   = lvl_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   assign data_o  = empty_o ? '0 : mem_q[rd_q];
   assign level_o = lvl_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push_ok) mem_q[wr_q] <= data_i;
   end
endmodule

// File: rtl/fir_out_stage.sv
// fir_out_stage: regenerates the FIR output valid, rounds/saturates y_out and
// buffers results for a valid/ready consumer with sticky sat/drop statistics.
module fir_out_stage
   import fir_pkg::*;
#(
   parameter int FIR_LATENCY = 5,
   parameter int Y_W         = Y_WIDTH,
   parameter int OUT_W       = OUT_DATA_WIDTH,
   parameter int SHIFT       = 12,
   parameter int DEPTH       = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_data_vld,
   input  logic [Y_W-1:0]         y_in,
   input  logic                   clear_stats,
   output logic [OUT_W-1:0]       out_data,
   output logic                   out_vld,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic                   sat_flag,
   output logic [DROP_CNT_W-1:0]  drop_cnt
);
   logic [FIR_LATENCY-1:0] vld_q, vld_d;
   logic                   sat_q, sat_d;
   logic [DROP_CNT_W-1:0]  drop_q, drop_d;
   logic                   capture, full, empty, pop, drop;
   round_sat_t             res;

   // Truncating cast keeps the shift expression valid even for a one-stage delay.
   assign vld_d   = FIR_LATENCY'({vld_q, in_data_vld});
   assign capture = vld_q[FIR_LATENCY-1];
   assign res     = fir_round_sat(y_in, SHIFT);
   assign pop     = out_vld & out_ready;
   assign drop    = capture & full & ~pop;
   assign sat_d   = (capture & res.sat) | (sat_q & ~clear_stats);
   assign drop_d  = drop ? (clear_stats ? DROP_CNT_W'(1) : drop_q + DROP_CNT_W'(drop_q != '1))
                         : (clear_stats ? '0 : drop_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q  <= '0;
         sat_q  <= 1'b0;
         drop_q <= '0;
      end else begin
         vld_q  <= vld_d;
         sat_q  <= sat_d;
         drop_q <= drop_d;
      end
   end

   assign out_vld  = ~empty;
   assign sat_flag = sat_q;
   assign drop_cnt = drop_q;

   fir_out_fifo #(.W(OUT_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (capture),
      .pop_i   (pop),
      .data_i  (res.val),
      .data_o  (out_data),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );
endmodule

// File: tb/tb_fir_out_stage.sv
// tb_fir_out_stage: directed plus random stimulus against a queue-based model of the output stage.
module tb_fir_out_stage;
   localparam int L  = 5;
   localparam int YW = 36;
   localparam int OW = 21;
   localparam int SH = 12;
   localparam int D  = 8;

   logic          clk = 1'b0;
   logic          reset, in_data_vld, clear_stats, out_ready;
   logic [YW-1:0] y_in;
   logic [OW-1:0] out_data;
   logic          out_vld, sat_flag;
   logic [3:0]    level;
   logic [15:0]   drop_cnt;

   int                n_tests = 0;
   int                n_fail  = 0;
   longint unsigned   mq[$];
   int                due[$];
   int                edge_n = 0;
   bit                m_sat  = 0;
   int                m_drop = 0;

   always #5 clk = ~clk;

   fir_out_stage #(.FIR_LATENCY(L), .Y_W(YW), .OUT_W(OW), .SHIFT(SH), .DEPTH(D)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_data_vld (in_data_vld),
      .y_in        (y_in),
      .clear_stats (clear_stats),
      .out_data    (out_data),
      .out_vld     (out_vld),
      .out_ready   (out_ready),
      .level       (level),
      .sat_flag    (sat_flag),
      .drop_cnt    (drop_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   function automatic longint unsigned ref_val(input longint unsigned y, output bit sat);
      longint unsigned s;
      longint unsigned mx;
      s   = (y + (SH > 0 ? (64'd1 << (SH - 1)) : 64'd0)) >> SH;
      mx  = (64'd1 << OW) - 1;
      sat = s > mx;
      return sat ? mx : s;
   endfunction

   // Each sampled valid is scheduled as a capture L edges later.
   task automatic model_step();
      bit              cap, full, pop, dr, sat;
      longint unsigned v;
      if (reset) begin
         mq.delete();
         due.delete();
         m_sat  = 0;
         m_drop = 0;
      end else begin
         cap = due.size() > 0 && due[0] == edge_n;
         if (cap) void'(due.pop_front());
         if (in_data_vld) due.push_back(edge_n + L);
         v    = ref_val(longint'(y_in), sat);
         pop  = mq.size() > 0 && out_ready;
         full = mq.size() == D;
         dr   = cap && full && !pop;
         if (pop) void'(mq.pop_front());
         if (cap && !dr) mq.push_back(v);
         if (cap && sat) m_sat = 1;
         else if (clear_stats) m_sat = 0;
         if (dr) m_drop = clear_stats ? 1 : (m_drop < 65535 ? m_drop + 1 : 65535);
         else if (clear_stats) m_drop = 0;
      end
      edge_n++;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check("out_vld", out_vld, mq.size() != 0);
      check("out_data", out_data, mq.size() != 0 ? mq[0] : 64'd0);
      check("level", level, mq.size());
      check("sat_flag", sat_flag, m_sat);
      check("drop_cnt", drop_cnt, m_drop);
   endtask

   task automatic one(input logic [YW-1:0] y, input logic [63:0] exp, input string tag);
      y_in = y;
      in_data_vld = 1;
      cycle();
      in_data_vld = 0;
      repeat (L) cycle();
      check(tag, out_data, exp);
      out_ready = 1;
      cycle();
      out_ready = 0;
   endtask

   initial begin
      reset = 1; in_data_vld = 0; clear_stats = 0; out_ready = 0; y_in = '0;
      cycle();
      cycle();
      reset = 0;
      check("rst_level", level, 0);
      check("rst_vld", out_vld, 0);
      check("rst_data", out_data, 0);
      check("rst_drop", drop_cnt, 0);
      repeat (7) cycle();

      // latency: out_vld exactly L+1 cycles after the valid
      y_in = 36'h1800;
      in_data_vld = 1;
      cycle();
      in_data_vld = 0;
      repeat (L - 1) cycle();
      check("lat_early", out_vld, 0);
      cycle();
      check("lat_vld", out_vld, 1);
      check("lat_data", out_data, 2);
      check("lat_level", level, 1);
      out_ready = 1;
      cycle();
      out_ready = 0;
      check("lat_drain", out_vld, 0);

      one(36'h7FF, 0, "rnd_lo");
      one(36'h800, 1, "rnd_hi");
      check("rnd_nosat", sat_flag, 0);

      one(36'h2_0000_0000, 64'h1FFFFF, "sat_data");
      check("sat_set", sat_flag, 1);
      clear_stats = 1;
      cycle();
      clear_stats = 0;
      check("sat_clr", sat_flag, 0);

      // ten back-to-back samples into an 8-deep FIFO with the consumer stalled
      out_ready = 0;
      for (int i = 0; i < 10 + L; i++) begin
         in_data_vld = i < 10;
         y_in = (i >= L && i - L < 10) ? YW'((i - L + 1) * 4096) : '0;
         cycle();
      end
      in_data_vld = 0;
      check("full_level", level, 8);
      check("full_drop", drop_cnt, 2);
      out_ready = 1;
      for (int k = 1; k <= 8; k++) begin
         check("full_order", out_data, k);
         cycle();
      end
      check("full_empty", out_vld, 0);
      out_ready = 0;

      // full FIFO, pop coincides with the capture of a ninth sample
      for (int i = 0; i < 9 + L; i++) begin
         in_data_vld = i < 9;
         y_in = 36'h3000;
         out_ready = i == 8 + L;
         cycle();
      end
      in_data_vld = 0;
      out_ready = 0;
      check("fpop_level", level, 8);
      check("fpop_drop", drop_cnt, 2);
      out_ready = 1;
      repeat (8) cycle();
      out_ready = 0;

      // reset with five buffered and three in flight
      for (int i = 0; i < L + 5; i++) begin
         in_data_vld = i < 8;
         cycle();
      end
      in_data_vld = 0;
      check("prerst_level", level, 5);
      reset = 1;
      cycle();
      reset = 0;
      check("mrst_level", level, 0);
      check("mrst_vld", out_vld, 0);
      repeat (L + 2) begin
         cycle();
         check("mrst_quiet", out_vld, 0);
      end

      // drop and clear_stats in the same cycle: the drop wins
      for (int i = 0; i < D + 1 + L; i++) begin
         in_data_vld = i < D + 1;
         clear_stats = i == D + L;
         cycle();
      end
      in_data_vld = 0;
      clear_stats = 0;
      check("clr_drop_ev", drop_cnt, 1);
      out_ready = 1;
      repeat (D) cycle();

      for (int i = 0; i < 3000; i++) begin
         int m;
         reset       = $urandom_range(0, 199) == 0;
         in_data_vld = $urandom_range(0, 2) != 0;
         out_ready   = $urandom_range(0, 3) != 0;
         clear_stats = $urandom_range(0, 49) == 0;
         m = $urandom_range(0, 3);
         case (m)
            0: y_in = YW'($urandom_range(0, 20000));
            1: y_in = {4'($urandom_range(0, 15)), 32'($urandom)};
            2: y_in = YW'(64'h1_FFFF_F000) + YW'($urandom_range(0, 8191)) - YW'(4096);
            default: y_in = {12'd0, 24'($urandom)};
         endcase
         cycle();
      end
      reset = 0; clear_stats = 0;

      // long stall to push drop_cnt into saturation
      out_ready = 0;
      in_data_vld = 1;
      y_in = 36'h5000;
      repeat (65560) cycle();
      check("drop_sat", drop_cnt, 16'hFFFF);
      clear_stats = 1;
      cycle();
      clear_stats = 0;
      check("drop_sat_clr", drop_cnt, 1);
      in_data_vld = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
